// File: rtl/max_pool_stream.sv
// max_pool_stream: streaming 2x2 stride-2 max pool over a raster pixel stream,
// keeping only a half-width line buffer of row-pair horizontal maxima.
module max_pool_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int IMGCOL = 32,
  parameter int IMGROW = 32,
  localparam int CW = $clog2(IMGCOL),
  localparam int RW = $clog2(IMGROW),
  localparam int OCW = (IMGCOL >= 4) ? $clog2(IMGCOL / 2) : 1,
  localparam int ORW = (IMGROW >= 4) ? $clog2(IMGROW / 2) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ORW-1:0]        out_row,
  output logic [OCW-1:0]        out_col,
  output logic                  out_eof
);
  logic [CW-1:0] col, c;
  logic [RW-1:0] row, r;
  logic [DATA_WIDTH-1:0] h_reg, hmax, lb_rd, pmax;
  logic [DATA_WIDTH-1:0] line_buf [IMGCOL/2];
  logic [OCW-1:0] idx;
  logic col_last, row_last, eof;
  // sof forces this pixel to (0,0) so a partial block is dropped
  assign c = in_sof ? '0 : col;
  assign r = in_sof ? '0 : row;
  assign col_last = c == CW'(IMGCOL - 1);
  assign row_last = r == RW'(IMGROW - 1);
  assign idx = OCW'(c >> 1);
  assign hmax = (in_data > h_reg) ? in_data : h_reg;
  assign lb_rd = line_buf[idx];
  assign pmax = (lb_rd > hmax) ? lb_rd : hmax;
  assign eof = ((r >> 1) == RW'(IMGROW / 2 - 1)) && ((c >> 1) == CW'(IMGCOL / 2 - 1));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
      h_reg <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_row <= '0;
      out_col <= '0;
      out_eof <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_eof <= 1'b0;
      if (in_valid) begin
        col <= col_last ? '0 : c + CW'(1);
        row <= col_last ? (row_last ? '0 : r + RW'(1)) : r;
        if (!c[0]) h_reg <= in_data;
        else if (r[0]) begin
          out_data <= pmax;
          out_row <= ORW'(r >> 1);
          out_col <= OCW'(c >> 1);
          out_valid <= 1'b1;
          out_eof <= eof;
        end
      end
    end
  end
  // even rows park their horizontal maxima for the odd row below
  always_ff @(posedge clk)
    if (in_valid && c[0] && !r[0]) line_buf[idx] <= hmax;
endmodule

// File: tb/tb_max_pool_stream.sv
// tb_max_pool_stream: directed checks of the 2x2 max-pool stage on a 4x4
// instance plus random back-to-back frames on the default 32x32 instance.
module tb_max_pool_stream;
  logic clk = 0, rst = 1, in_valid = 0, in_sof = 0;
  logic [7:0] in_data = 0;
  logic v4, e4, row4, col4, v32, e32;
  logic [7:0] d4, d32;
  logic [3:0] row32, col32;
  int n_cmp = 0, n_bad = 0;
  localparam logic [7:0] MP [2][4][4] = '{
    '{'{200, 3, 4, 5}, '{3, 200, 4, 5}, '{3, 4, 200, 5}, '{3, 4, 5, 200}},
    '{'{9, 9, 9, 9}, '{255, 0, 0, 0}, '{0, 0, 0, 255}, '{0, 0, 255, 0}}};
  localparam logic [7:0] MP_EXP [2][4] = '{'{200, 200, 200, 200}, '{9, 255, 255, 255}};
  localparam logic [7:0] RAMP_EXP [4] = '{5, 7, 13, 15};

  max_pool_stream #(.DATA_WIDTH(8), .IMGCOL(4), .IMGROW(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .out_valid(v4), .out_data(d4), .out_row(row4), .out_col(col4), .out_eof(e4));

  max_pool_stream u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .out_valid(v32), .out_data(d32), .out_row(row32), .out_col(col32), .out_eof(e32));

  always #5 clk = ~clk;

  task automatic send(input logic v, input logic s, input logic [7:0] d);
    @(negedge clk);
    in_valid = v;
    in_sof = s;
    in_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int cnt = 0, k = 0;
    logic ev;
    #1 rst = 0;
    #10;
    n_cmp++; if (v4 !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", v4); end
    n_cmp++; if (e4 !== 1'b0) begin n_bad++; $display("FAIL reset_eof got %b exp 0", e4); end
    n_cmp++; if ({d4, row4, col4} !== 10'h0) begin n_bad++; $display("FAIL reset_data got %h exp 0", {d4, row4, col4}); end
    @(negedge clk) rst = 1;
    for (int i = 0; i < 16; i++) begin
      send(1, 0, 8'(i));
      if (v4) cnt++;
    end
    send(0, 0, 0);
    if (v4) cnt++;
    n_cmp++; if (cnt != 4) begin n_bad++; $display("FAIL reset_count got %0d exp 4", cnt); end
    for (int i = 0; i < 6; i++) send(1, 0, 8'(50 + i));
    n_cmp++; if ({v4, d4} !== {1'b1, 8'd55}) begin n_bad++; $display("FAIL midreset_pre got %h exp %h", {v4, d4}, {1'b1, 8'd55}); end
    in_valid = 0;
    rst = 0;
    #1;
    n_cmp++; if ({v4, e4, d4} !== 10'h0) begin n_bad++; $display("FAIL midreset_async got %h exp 0", {v4, e4, d4}); end
    @(negedge clk) rst = 1;
    for (int i = 0; i < 16; i++) begin
      send(1, 0, 8'(i));
      ev = (i % 2 == 1) && ((i / 4) % 2 == 1);
      n_cmp++; if ({v4, e4} !== {ev, ev && k == 3}) begin n_bad++; $display("FAIL postreset_valid i=%0d got %b exp %b", i, {v4, e4}, {ev, ev && k == 3}); end
      if (ev) begin
        n_cmp++; if ({d4, row4, col4} !== {RAMP_EXP[k], 1'(k / 2), 1'(k % 2)}) begin n_bad++; $display("FAIL postreset_out k=%0d got %h exp %h", k, {d4, row4, col4}, {RAMP_EXP[k], 1'(k / 2), 1'(k % 2)}); end
        k++;
      end
    end
    send(0, 0, 0);
  endtask

  task automatic test_ramp;
    int k = 0;
    logic ev;
    for (int i = 0; i < 16; i++) begin
      send(1, i == 0, 8'(i));
      ev = (i % 2 == 1) && ((i / 4) % 2 == 1);
      n_cmp++; if ({v4, e4} !== {ev, ev && k == 3}) begin n_bad++; $display("FAIL ramp_valid i=%0d got %b exp %b", i, {v4, e4}, {ev, ev && k == 3}); end
      if (ev) begin
        n_cmp++; if ({d4, row4, col4} !== {RAMP_EXP[k], 1'(k / 2), 1'(k % 2)}) begin n_bad++; $display("FAIL ramp_out k=%0d got %h exp %h", k, {d4, row4, col4}, {RAMP_EXP[k], 1'(k / 2), 1'(k % 2)}); end
        k++;
      end
    end
    send(0, 0, 0);
    n_cmp++; if (v4 !== 1'b0) begin n_bad++; $display("FAIL ramp_pulse got %b exp 0", v4); end
  endtask

  task automatic test_max_pos;
    logic [7:0] px [16];
    logic ev;
    int k;
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < 4; b++)
        for (int q = 0; q < 4; q++)
          px[(2 * (b / 2) + q / 2) * 4 + 2 * (b % 2) + q % 2] = MP[f][b][q];
      k = 0;
      for (int i = 0; i < 16; i++) begin
        send(1, i == 0, px[i]);
        ev = (i % 2 == 1) && ((i / 4) % 2 == 1);
        n_cmp++; if (v4 !== ev) begin n_bad++; $display("FAIL maxpos_valid f=%0d i=%0d got %b exp %b", f, i, v4, ev); end
        if (ev) begin
          n_cmp++; if ({d4, e4} !== {MP_EXP[f][k], k == 3}) begin n_bad++; $display("FAIL maxpos_out f=%0d k=%0d got %h exp %h", f, k, {d4, e4}, {MP_EXP[f][k], k == 3}); end
          k++;
        end
      end
    end
    send(0, 0, 0);
  endtask

  task automatic test_stall;
    int k = 0, g;
    logic ev;
    for (int i = 0; i < 16; i++) begin
      g = $urandom_range(0, 5);
      for (int j = 0; j < g; j++) begin
        send(0, 0, 8'hA5);
        n_cmp++; if (v4 !== 1'b0) begin n_bad++; $display("FAIL stall_idle i=%0d got %b exp 0", i, v4); end
        if (k > 0) begin
          n_cmp++; if (d4 !== RAMP_EXP[k - 1]) begin n_bad++; $display("FAIL stall_hold i=%0d got %h exp %h", i, d4, RAMP_EXP[k - 1]); end
        end
      end
      send(1, i == 0, 8'(i));
      ev = (i % 2 == 1) && ((i / 4) % 2 == 1);
      n_cmp++; if ({v4, e4} !== {ev, ev && k == 3}) begin n_bad++; $display("FAIL stall_valid i=%0d got %b exp %b", i, {v4, e4}, {ev, ev && k == 3}); end
      if (ev) begin
        n_cmp++; if ({d4, row4, col4} !== {RAMP_EXP[k], 1'(k / 2), 1'(k % 2)}) begin n_bad++; $display("FAIL stall_out k=%0d got %h exp %h", k, {d4, row4, col4}, {RAMP_EXP[k], 1'(k / 2), 1'(k % 2)}); end
        k++;
      end
    end
    send(0, 0, 0);
  endtask

  task automatic test_resync;
    int k = 0;
    logic ev;
    for (int i = 0; i < 6; i++) send(1, i == 0, 8'(100 + i));
    for (int i = 0; i < 16; i++) begin
      send(1, i == 0, 8'(i));
      ev = (i % 2 == 1) && ((i / 4) % 2 == 1);
      n_cmp++; if ({v4, e4} !== {ev, ev && k == 3}) begin n_bad++; $display("FAIL resync_valid i=%0d got %b exp %b", i, {v4, e4}, {ev, ev && k == 3}); end
      if (ev) begin
        n_cmp++; if ({d4, row4, col4} !== {RAMP_EXP[k], 1'(k / 2), 1'(k % 2)}) begin n_bad++; $display("FAIL resync_out k=%0d got %h exp %h", k, {d4, row4, col4}, {RAMP_EXP[k], 1'(k / 2), 1'(k % 2)}); end
        k++;
      end
    end
    send(0, 0, 0);
  endtask

  task automatic test_default_size;
    logic [7:0] px [32][32];
    logic [7:0] m;
    logic ev;
    int cnt;
    @(negedge clk);
    in_valid = 0;
    rst = 0;
    @(negedge clk) rst = 1;
    for (int f = 0; f < 2; f++) begin
      cnt = 0;
      for (int r = 0; r < 32; r++)
        for (int c = 0; c < 32; c++) begin
          px[r][c] = 8'($urandom_range(0, 255));
          send(1, f == 0 && r == 0 && c == 0, px[r][c]);
          ev = (r % 2 == 1) && (c % 2 == 1);
          if (v32) cnt++;
          n_cmp++; if ({v32, e32} !== {ev, ev && r == 31 && c == 31}) begin n_bad++; $display("FAIL big_valid f=%0d r=%0d c=%0d got %b exp %b", f, r, c, {v32, e32}, {ev, ev && r == 31 && c == 31}); end
          if (ev) begin
            m = px[r - 1][c - 1];
            if (px[r - 1][c] > m) m = px[r - 1][c];
            if (px[r][c - 1] > m) m = px[r][c - 1];
            if (px[r][c] > m) m = px[r][c];
            n_cmp++; if ({d32, row32, col32} !== {m, 4'(r / 2), 4'(c / 2)}) begin n_bad++; $display("FAIL big_out f=%0d r=%0d c=%0d got %h exp %h", f, r, c, {d32, row32, col32}, {m, 4'(r / 2), 4'(c / 2)}); end
          end
        end
      n_cmp++; if (cnt != 256) begin n_bad++; $display("FAIL big_count f=%0d got %0d exp 256", f, cnt); end
    end
    send(0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_max_pos();
    test_stall();
    test_resync();
    test_default_size();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
